interboard_rx: RTL and testbench

- Receive end of the 4-phase Request/Ack interboard link between the two player boards.
- Samples 6-bit words from the peer transmitter, reassembles a 24-bit message frame and acknowledges each word.
- Presents the decoded move (msg_type, move_dir, block_x, block_y, card, sel_len) to memory handling as a one-cycle strobe, or as a reset pulse when the frame is a reset message.
- Sits behind the tri-state pad logic; sees only plain inputs and one plain output.

---
 rtl/interboard_rx.sv | 166 ++++++++++++++++
 tb/tb_interboard_rx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/interboard_rx.sv
// Receive side of the 4-phase Request/Ack interboard link: reassembles four 6-bit words into a 24-bit frame and strobes the decoded move.
// Optional INTERBOARD_PARITY_EN: enforce even parity over frame[23:1] and drop mismatching frames with frame_error.
module interboard_rx #(
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter logic [3:0]  RST_MSG_TYPE   = 4'hF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_in,
    input  logic [5:0] data_in,
    output logic       ack_out,
    output logic       interboard_en,
    output logic       interboard_rst,
    output logic [3:0] interboard_msg_type,
    output logic       interboard_move_dir,
    output logic [4:0] interboard_block_x,
    output logic [2:0] interboard_block_y,
    output logic [5:0] interboard_card,
    output logic [2:0] interboard_sel_len,
    output logic       frame_error
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TC_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, CAPTURE, ACK_HI, WAIT_NEXT, DELIVER} state_t;

    state_t        state_q;
    logic          req_meta_q, req_s_q;
    logic [1:0]    wcnt_q;
    logic [23:0]   frame_q;
    logic [CW-1:0] tcnt_q;
    logic          ack_q, en_q, rstp_q, err_q;
    logic [3:0]    msg_type_q;
    logic          move_dir_q;
    logic [4:0]    block_x_q;
    logic [2:0]    block_y_q;
    logic [5:0]    card_q;
    logic [2:0]    sel_len_q;

    logic [23:0]   frame_d;
    logic          frame_ok_d;
    logic          timeout_d;
    logic          unused_bits;

    assign frame_d   = {frame_q[17:0], data_in};
    assign timeout_d = (tcnt_q == TC_LAST);
`ifdef INTERBOARD_PARITY_EN
    assign frame_ok_d = ~(^frame_q[23:1]);
`else
    assign frame_ok_d = 1'b1;
`endif
    // Spare bit (and parity when unchecked) carry no information here.
    assign unused_bits = ^frame_q[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            req_meta_q <= 1'b0;
            req_s_q    <= 1'b0;
            wcnt_q     <= 2'd0;
            frame_q    <= 24'd0;
            tcnt_q     <= '0;
            ack_q      <= 1'b0;
            en_q       <= 1'b0;
            rstp_q     <= 1'b0;
            err_q      <= 1'b0;
            msg_type_q <= 4'd0;
            move_dir_q <= 1'b0;
            block_x_q  <= 5'd0;
            block_y_q  <= 3'd0;
            card_q     <= 6'd0;
            sel_len_q  <= 3'd0;
        end else begin
            req_meta_q <= req_in;
            req_s_q    <= req_meta_q;
            en_q       <= 1'b0;
            rstp_q     <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    ack_q  <= 1'b0;
                    wcnt_q <= 2'd0;
                    tcnt_q <= '0;
                    if (req_s_q) state_q <= CAPTURE;
                end
                CAPTURE: begin
                    frame_q <= frame_d;
                    ack_q   <= 1'b1;
                    tcnt_q  <= '0;
                    state_q <= ACK_HI;
                end
                ACK_HI: begin
                    // A req_s transition always beats a coincident timeout.
                    if (!req_s_q) begin
                        ack_q  <= 1'b0;
                        tcnt_q <= '0;
                        if (wcnt_q == 2'd3) begin
                            state_q <= DELIVER;
                        end else begin
                            wcnt_q  <= wcnt_q + 2'd1;
                            state_q <= WAIT_NEXT;
                        end
                    end else if (timeout_d) begin
                        err_q   <= 1'b1;
                        ack_q   <= 1'b0;
                        wcnt_q  <= 2'd0;
                        tcnt_q  <= '0;
                        state_q <= IDLE;
                    end else begin
                        tcnt_q <= tcnt_q + CW'(1);
                    end
                end
                WAIT_NEXT: begin
                    ack_q <= 1'b0;
                    if (req_s_q) begin
                        tcnt_q  <= '0;
                        state_q <= CAPTURE;
                    end else if (timeout_d) begin
                        err_q   <= 1'b1;
                        wcnt_q  <= 2'd0;
                        tcnt_q  <= '0;
                        state_q <= IDLE;
                    end else begin
                        tcnt_q <= tcnt_q + CW'(1);
                    end
                end
                DELIVER: begin
                    ack_q  <= 1'b0;
                    wcnt_q <= 2'd0;
                    tcnt_q <= '0;
                    if (!frame_ok_d) begin
                        err_q <= 1'b1;
                    end else if (frame_q[23:20] == RST_MSG_TYPE) begin
                        rstp_q <= 1'b1;
                    end else begin
                        en_q       <= 1'b1;
                        msg_type_q <= frame_q[23:20];
                        move_dir_q <= frame_q[19];
                        block_x_q  <= frame_q[18:14];
                        block_y_q  <= frame_q[13:11];
                        card_q     <= frame_q[10:5];
                        sel_len_q  <= frame_q[4:2];
                    end
                    state_q <= IDLE;
                end
                default: begin
                    ack_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack_out             = ack_q;
    assign interboard_en       = en_q;
    assign interboard_rst      = rstp_q;
    assign frame_error         = err_q;
    assign interboard_msg_type = msg_type_q;
    assign interboard_move_dir = move_dir_q;
    assign interboard_block_x  = block_x_q;
    assign interboard_block_y  = block_y_q;
    assign interboard_card     = card_q;
    assign interboard_sel_len  = sel_len_q;

endmodule

// File: tb/tb_interboard_rx.sv
// Bench for interboard_rx: peer transmitter model, table of frames, scoreboard of expected strobes.
module tb_interboard_rx;

    localparam int K_EN  = 1;
    localparam int K_RST = 2;
    localparam int K_ERR = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_in = 1'b0;
    logic [5:0] data_in = 6'd0;
    logic       ack_out, ib_en, ib_rst, frame_error, move_dir;
    logic [3:0] msg_type;
    logic [4:0] block_x;
    logic [2:0] block_y, sel_len;
    logic [5:0] card;

    interboard_rx #(.TIMEOUT_CYCLES(50), .RST_MSG_TYPE(4'hF)) dut (
        .clk(clk), .rst(rst), .req_in(req_in), .data_in(data_in), .ack_out(ack_out),
        .interboard_en(ib_en), .interboard_rst(ib_rst),
        .interboard_msg_type(msg_type), .interboard_move_dir(move_dir),
        .interboard_block_x(block_x), .interboard_block_y(block_y),
        .interboard_card(card), .interboard_sel_len(sel_len), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [21:0] f;
    } exp_t;

    typedef struct {
        logic [3:0][5:0] w;
        exp_t            e;
    } vec_t;

    exp_t        sb[$];
    logic [21:0] last_f = 22'd0;
    int          checks = 0;
    int          errors = 0;
    int          ack_rises = 0;
    logic        prev_ack = 1'b0;

    function automatic logic [21:0] got_fields();
        return {msg_type, move_dir, block_x, block_y, card, sel_len};
    endfunction

    // Scoreboard: every strobe must match the oldest expected frame outcome.
    always @(negedge clk) begin
        if (!rst) begin
            if (ack_out && !prev_ack) ack_rises++;
            prev_ack = ack_out;
            if (ib_en || ib_rst || frame_error) begin
                exp_t e;
                int   k;
                checks++;
                k = ib_en ? K_EN : (ib_rst ? K_RST : K_ERR);
                if (int'(ib_en) + int'(ib_rst) + int'(frame_error) > 1) begin
                    errors++;
                    $display("FAIL strobe_excl got en=%0b rst=%0b err=%0b required one", ib_en, ib_rst, frame_error);
                end else if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe got kind %0d required none", k);
                end else begin
                    e = sb.pop_front();
                    if (k != e.kind) begin
                        errors++;
                        $display("FAIL strobe_kind got %0d required %0d", k, e.kind);
                    end
                    checks++;
                    if (e.kind == K_EN) last_f = e.f;
                    if (got_fields() !== last_f) begin
                        errors++;
                        $display("FAIL fields got %h required %h", got_fields(), last_f);
                    end
                end
            end
        end else begin
            prev_ack = 1'b0;
        end
    end

    task automatic wait_ack(input logic v);
        int i = 0;
        while (ack_out !== v && i < 300) begin
            @(negedge clk);
            i++;
        end
        if (ack_out !== v) begin
            checks++;
            errors++;
            $display("FAIL ack_wait got %b required %b", ack_out, v);
        end
    endtask

    task automatic send_word(input logic [5:0] w);
        @(negedge clk);
        data_in = w;
        req_in  = 1'b1;
        wait_ack(1'b1);
        @(negedge clk);
        req_in = 1'b0;
        wait_ack(1'b0);
    endtask

    task automatic send_frame(input vec_t v);
        sb.push_back(v.e);
        for (int i = 0; i < 4; i++) send_word(v.w[i]);
    endtask

    task automatic drain();
        int i = 0;
        while (sb.size() != 0 && i < 100) begin
            @(negedge clk);
            i++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending required 0", sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    localparam logic [21:0] F_CLEAN = {4'd3, 1'b1, 5'd17, 3'd5, 6'd42, 3'd2};
    localparam logic [21:0] F_V4    = {4'd1, 1'b0, 5'd3, 3'd2, 6'd7, 3'd4};

    vec_t vecs[4];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, cyc;
        vecs[0].w = {6'h0A, 6'h35, 6'h06, 6'h0F}; vecs[0].e = '{K_EN, F_CLEAN};
`ifdef INTERBOARD_PARITY_EN
        vecs[1].w = {6'h08, 6'h35, 6'h06, 6'h0F}; vecs[1].e = '{K_ERR, 22'd0};
`else
        vecs[1].w = {6'h08, 6'h35, 6'h06, 6'h0F}; vecs[1].e = '{K_EN, F_CLEAN};
`endif
        vecs[2].w = {6'h0A, 6'h35, 6'h06, 6'h3C}; vecs[2].e = '{K_RST, 22'd0};
        vecs[3].w = {6'h30, 6'h03, 6'h0D, 6'h04}; vecs[3].e = '{K_EN, F_V4};

        repeat (3) @(negedge clk);
        checks++;
        if ({ack_out, ib_en, ib_rst, frame_error, got_fields()} !== 26'd0) begin
            errors++;
            $display("FAIL reset_state got %h required 0", {ack_out, ib_en, ib_rst, frame_error, got_fields()});
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            r0 = ack_rises;
            send_frame(vecs[i]);
            drain();
            if (i == 0) begin
                checks++;
                if (ack_rises - r0 != 4) begin
                    errors++;
                    $display("FAIL ack_toggles got %0d required 4", ack_rises - r0);
                end
            end
        end

        // Timeout after two words of a frame.
        sb.push_back('{K_ERR, 22'd0});
        send_word(6'h0F);
        send_word(6'h06);
        cyc = 0;
        while (!frame_error && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc < 48 || cyc > 52) begin
            errors++;
            $display("FAIL timeout_cycle got %0d required 50", cyc);
        end
        checks++;
        if (ack_out !== 1'b0) begin
            errors++;
            $display("FAIL timeout_ack got %b required 0", ack_out);
        end
        drain();
        send_frame(vecs[0]);
        drain();

        // Asynchronous reset while ack is high during word2.
        send_word(6'h04);
        send_word(6'h0D);
        @(negedge clk);
        data_in = 6'h03;
        req_in  = 1'b1;
        wait_ack(1'b1);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ack_out, ib_en, ib_rst, frame_error, got_fields()} !== 26'd0) begin
            errors++;
            $display("FAIL async_rst got %h required 0", {ack_out, ib_en, ib_rst, frame_error, got_fields()});
        end
        last_f = 22'd0;
        req_in = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        send_frame(vecs[3]);
        drain();

        // Back-to-back frames with no idle gap.
        send_frame(vecs[3]);
        send_frame(vecs[0]);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
